// File: rtl/exception_ctrl_if.sv
// exception_ctrl_if: core-side bus of the exception controller; exc_mask exists only when EXC_MASK_EN is defined
interface exception_ctrl_if #(parameter int NUM_SRC = 4, parameter int ST_W = 4);
  logic [NUM_SRC-1:0] exc_req;
  logic eret;
  logic [63:0] imem_addr_F, NextPC_F, PCBranch_E;
  logic [ST_W-1:0] estatus;
  logic [1:0] sys_sel;
`ifdef EXC_MASK_EN
  logic [NUM_SRC-1:0] exc_mask;
`endif
  logic exc_take, exc_ack, in_handler;
  logic [63:0] exc_vector, sys_rdata, PCBranch;
  logic [NUM_SRC-1:0] pending;
  modport master(
`ifdef EXC_MASK_EN
    output exc_mask,
`endif
    output exc_req, eret, imem_addr_F, NextPC_F, PCBranch_E, estatus, sys_sel,
    input exc_take, exc_vector, exc_ack, in_handler, pending, sys_rdata, PCBranch
  );
  modport slave(
`ifdef EXC_MASK_EN
    input exc_mask,
`endif
    input exc_req, eret, imem_addr_F, NextPC_F, PCBranch_E, estatus, sys_sel,
    output exc_take, exc_vector, exc_ack, in_handler, pending, sys_rdata, PCBranch
  );
endinterface

// File: rtl/exception_ctrl.sv
// exception_ctrl: fixed-priority exception latch, fetch redirect and ERET return; EXC_MASK_EN adds per-source masking
module exception_ctrl #(
  parameter int NUM_SRC = 4,
  parameter logic [63:0] VEC_BASE = 64'hD8,
  parameter logic [63:0] VEC_STRIDE = 64'h20,
  parameter int ST_W = 4
) (
  input logic clk,
  input logic reset,
  exception_ctrl_if.slave bus
);
  localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  localparam logic [1:0] IDLE = 2'd0, REDIRECT = 2'd1, HANDLER = 2'd2;
  logic [1:0] state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d, elig, clr;
  logic [SW-1:0] cur_q, cur_d, sel;
  logic [63:0] elr_q, elr_d, err_q, err_d;
  logic [ST_W+3:0] esr_q, esr_d;
  logic start, ack;
`ifdef EXC_MASK_EN
  assign elig = pending_q & ~bus.exc_mask;
`else
  assign elig = pending_q;
`endif
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (elig[i]) sel = SW'(i);
  end
  assign start = state_q == IDLE && |elig;
  assign bus.exc_vector = VEC_BASE + 64'(cur_q) * VEC_STRIDE;
  assign bus.exc_take = state_q == REDIRECT;
  assign ack = state_q == REDIRECT && bus.imem_addr_F == bus.exc_vector;
  assign bus.exc_ack = ack;
  assign bus.in_handler = state_q == HANDLER;
  assign bus.pending = pending_q;
  assign bus.PCBranch = bus.eret ? err_q : bus.PCBranch_E;
  assign bus.sys_rdata = bus.sys_sel == 2'd0 ? err_q :
                         bus.sys_sel == 2'd1 ? elr_q :
                         bus.sys_sel == 2'd2 ? 64'(esr_q) : 64'(pending_q);
  assign clr = ack ? NUM_SRC'(1) << cur_q : '0;
  // a request arriving on the acknowledge edge re-arms its own bit
  always_comb begin
    pending_d = (pending_q & ~clr) | bus.exc_req;
    state_d = start ? REDIRECT : ack ? HANDLER : (state_q == HANDLER && bus.eret) ? IDLE : state_q;
    cur_d = start ? sel : cur_q;
    elr_d = start ? bus.imem_addr_F : elr_q;
    err_d = start ? bus.NextPC_F : err_q;
    esr_d = start ? {4'(sel), bus.estatus} : esr_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pending_q <= '0;
      cur_q <= '0;
      elr_q <= '0;
      err_q <= '0;
      esr_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      cur_q <= cur_d;
      elr_q <= elr_d;
      err_q <= err_d;
      esr_q <= esr_d;
    end
  end
endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_exception_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  exception_ctrl_if #(.NUM_SRC(4), .ST_W(4)) bus();
  exception_ctrl #(.NUM_SRC(4), .VEC_BASE(64'hD8), .VEC_STRIDE(64'h20), .ST_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  // model: m_st 0 = idle, 1 = redirecting to vector, 2 = in handler
  int m_st, m_cur, n_st, n_cur;
  logic [3:0] m_pend, n_pend;
  logic [63:0] m_elr, m_err, m_esr, n_elr, n_err, n_esr;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st <= 0; m_cur <= 0; m_pend <= '0; m_elr <= '0; m_err <= '0; m_esr <= '0;
    end else begin
      m_st <= n_st; m_cur <= n_cur; m_pend <= n_pend; m_elr <= n_elr; m_err <= n_err; m_esr <= n_esr;
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic zero_inputs();
    bus.exc_req = '0; bus.eret = 1'b0; bus.imem_addr_F = '0; bus.NextPC_F = '0;
    bus.PCBranch_E = '0; bus.estatus = '0; bus.sys_sel = 2'd0;
`ifdef EXC_MASK_EN
    bus.exc_mask = '0;
`endif
    n_st = 0; n_cur = 0; n_pend = '0; n_elr = '0; n_err = '0; n_esr = '0;
  endtask
  task automatic drive(input logic [3:0] req, input logic er, input logic [63:0] addr, npc, pcbe,
                       input logic [3:0] st, input logic [1:0] sel, input logic [3:0] msk, input bit hit);
    logic [63:0] vec, rd;
    logic [3:0] em, elig;
    logic ack;
    int pick;
    @(negedge clk);
    vec = 64'hD8 + 64'(m_cur) * 64'h20;
    bus.exc_req = req; bus.eret = er; bus.imem_addr_F = hit ? vec : addr; bus.NextPC_F = npc;
    bus.PCBranch_E = pcbe; bus.estatus = st; bus.sys_sel = sel;
`ifdef EXC_MASK_EN
    bus.exc_mask = msk; em = msk;
`else
    em = msk & 4'd0;
`endif
    #1;
    ack = m_st == 1 && bus.imem_addr_F == vec;
    rd = sel == 0 ? m_err : sel == 1 ? m_elr : sel == 2 ? m_esr : 64'(m_pend);
    check("take", bus.exc_take, m_st == 1);
    check("vector", bus.exc_vector, vec);
    check("ack", bus.exc_ack, ack);
    check("in_handler", bus.in_handler, m_st == 2);
    check("pending", bus.pending, m_pend);
    check("sys_rdata", bus.sys_rdata, rd);
    check("pcbranch", bus.PCBranch, er ? m_err : pcbe);
    elig = m_pend & ~em;
    pick = -1;
    for (int i = 0; i < 4; i++) if (elig[i]) begin pick = i; break; end
    n_st = m_st; n_cur = m_cur; n_elr = m_elr; n_err = m_err; n_esr = m_esr;
    n_pend = (m_pend & ~(ack ? 4'(1 << m_cur) : 4'd0)) | req;
    if (m_st == 0 && pick >= 0) begin
      n_st = 1; n_cur = pick; n_elr = bus.imem_addr_F; n_err = npc; n_esr = 64'(pick * 16 + int'(st));
    end else if (ack) n_st = 2;
    else if (m_st == 2 && er) n_st = 0;
  endtask
  initial begin
    zero_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_take", bus.exc_take, 1'b0);
    check("rst_handler", bus.in_handler, 1'b0);
    check("rst_pending", bus.pending, 4'd0);
    check("rst_err", bus.sys_rdata, 64'd0);
    @(negedge clk) reset = 1'b0;
    // single source 2
    drive(4'b0100, 0, 64'h40, 64'h44, 0, 4'd5, 2'd3, 0, 0);
    drive(4'b0000, 0, 64'h40, 64'h44, 0, 4'd5, 2'd3, 0, 0);
    check("single_pending", bus.sys_rdata, 64'h4);
    drive(0, 0, 64'h40, 64'h44, 0, 4'd5, 2'd0, 0, 0);
    check("single_take", bus.exc_take, 1'b1);
    check("single_vec", bus.exc_vector, 64'h118);
    check("single_noack", bus.exc_ack, 1'b0);
    drive(0, 0, 64'h118, 0, 0, 0, 2'd0, 0, 0);
    check("single_ack", bus.exc_ack, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    check("single_handler", bus.in_handler, 1'b1);
    check("sweep_err", bus.sys_rdata, 64'h44);
    drive(0, 0, 0, 0, 0, 0, 2'd1, 0, 0);
    check("sweep_elr", bus.sys_rdata, 64'h40);
    drive(0, 0, 0, 0, 0, 0, 2'd2, 0, 0);
    check("sweep_esr", bus.sys_rdata, 64'h25);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 0, 0);
    check("sweep_pend", bus.sys_rdata, 64'h0);
    drive(0, 1, 0, 0, 64'h200, 0, 2'd0, 0, 0);
    check("eret_pcb", bus.PCBranch, 64'h44);
    drive(0, 0, 0, 0, 64'h200, 0, 2'd0, 0, 0);
    check("eret_idle", bus.in_handler, 1'b0);
    check("pcb_follow", bus.PCBranch, 64'h200);
    // priority: sources 1 and 3 together
    drive(4'b1010, 0, 0, 0, 0, 0, 2'd3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 0, 0);
    check("prio_vec1", bus.exc_vector, 64'hF8);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 0, 0);
    check("prio_pend", bus.sys_rdata, 64'h8);
    drive(0, 1, 0, 0, 0, 0, 2'd3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 0, 0);
    check("prio_idle", bus.exc_take, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 0, 0);
    check("prio_vec3", bus.exc_vector, 64'h138);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 0, 1);
    drive(0, 1, 0, 0, 0, 0, 2'd3, 0, 0);
`ifdef EXC_MASK_EN
    drive(4'b0001, 0, 0, 0, 0, 0, 2'd3, 4'b0001, 0);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 4'b0001, 0);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 4'b0001, 0);
    check("mask_block", bus.exc_take, 1'b0);
    check("mask_keep", bus.sys_rdata, 64'h1);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 4'b0000, 0);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 4'b0000, 0);
    check("mask_take", bus.exc_take, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 0, 1);
    drive(0, 1, 0, 0, 0, 0, 2'd3, 0, 0);
`endif
    // reset while in handler with another source pending
    drive(4'b0001, 0, 0, 0, 0, 0, 2'd3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 0, 1);
    drive(4'b0100, 0, 0, 0, 0, 0, 2'd3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 2'd3, 0, 0);
    check("pre_rst_handler", bus.in_handler, 1'b1);
    #2 reset = 1'b1;
    zero_inputs();
    bus.sys_sel = 2'd3;
    #1;
    check("mid_rst_handler", bus.in_handler, 1'b0);
    check("mid_rst_take", bus.exc_take, 1'b0);
    check("mid_rst_pend", bus.sys_rdata, 64'h0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    drive(4'b0001, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    check("post_rst_take", bus.exc_take, 1'b1);
    check("post_rst_vec", bus.exc_vector, 64'hD8);
    for (int n = 0; n < 1500; n++)
      drive($urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'd0,
            $urandom_range(0, 5) == 0, 64'($urandom_range(0, 511)), {$urandom, $urandom},
            {$urandom, $urandom}, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'd0, $urandom_range(0, 2) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
